// File: rtl/parity_arb_pkg.sv
// Shared definitions for the parity-check arbiter: FSM encodings and default sizing.
package parity_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_RESP  = ST_RESP
  } state_t;

endpackage

// File: rtl/parity_checker.sv
// Combinational nibble parity check; trig selects odd parity, out flags a mismatch.
module parity_checker (
  input  logic [3:0] data,
  input  logic       parity,
  input  logic       trig,
  output logic       out
);

  assign out = (^{data, parity}) ^ trig;

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin sharing of one parity_checker between NREQ requesters, with
// a three-state sequence per request and saturating per-requester error counters.
module parity_check_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*4-1:0]     req_data,
  input  logic [NREQ-1:0]       req_parity,
  input  logic [NREQ-1:0]       req_odd,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_err,
  input  logic                  clr_cnt,
  output logic [NREQ*CNT_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  logic [IDX_W-1:0]  r_last;
  logic [3:0]        r_data;
  logic              r_par;
  logic              r_odd;
  logic              r_err_q;
  logic [NREQ-1:0]   r_rsp_valid;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_cnt [NREQ];

  logic [IDX_W-1:0]  w_pick;
  logic              w_err;

  // Nearest valid index after r_last wins; descending scan lets the closest overwrite.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    int idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (valid[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign w_pick = rr_pick(req_valid, r_last);

  always_comb begin
    req_ready = '0;
    if (!rst && r_state == S_IDLE && |req_valid) req_ready[w_pick] = 1'b1;
  end

  parity_checker u_checker (
    .data   (r_data),
    .parity (r_par),
    .trig   (r_odd),
    .out    (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDX_W'(NREQ - 1);
      r_data      <= '0;
      r_par       <= 1'b0;
      r_odd       <= 1'b0;
      r_err_q     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_last  <= w_pick;
            r_data  <= req_data[int'(w_pick)*4 +: 4];
            r_par   <= req_parity[w_pick];
            r_odd   <= req_odd[w_pick];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err_q             <= w_err;
          r_rsp_valid[r_last] <= 1'b1;
          r_rsp_err           <= w_err;
          r_state             <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (clr_cnt)
          r_cnt[i] <= '0;
        else if (r_state == S_RESP && r_err_q && int'(r_last) == i && r_cnt[i] != CNT_MAX)
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    assign err_cnt[CNT_W*gi +: CNT_W] = r_cnt[gi];
  end

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter; a second instance with 2-bit counters covers saturation.
module tb_parity_check_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [7:0]  req_data;
  logic [1:0]  req_parity;
  logic [1:0]  req_odd;
  logic        clr_cnt;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [15:0] err_cnt;
  logic [1:0]  req_ready2;
  logic [1:0]  rsp_valid2;
  logic        rsp_err2;
  logic [3:0]  err_cnt2;

  int errors = 0;
  int checks = 0;

  parity_check_arbiter #(.NREQ(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_parity(req_parity), .req_odd(req_odd), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  parity_check_arbiter #(.NREQ(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_parity(req_parity), .req_odd(req_odd), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request from requester idx on an otherwise idle bus; returns one cycle after RESP.
  task automatic do_req(input int idx, input logic [3:0] d, input logic p, input logic o,
                        input logic exp_err, input string nm);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    req_valid[idx] = 1'b1;
    req_data[idx*4 +: 4] = d;
    req_parity[idx] = p;
    req_odd[idx] = o;
    @(negedge clk);
    checks++;
    if (req_ready !== oh) begin
      errors++; $display("FAIL %s ready: got %b expected %b", nm, req_ready, oh);
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    req_data[idx*4 +: 4] = ~d;
    req_parity[idx] = ~p;
    req_odd[idx] = ~o;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++; $display("FAIL %s check_cycle: got rsp_valid=%b ready=%b expected 00/00", nm, rsp_valid, req_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== oh) begin
      errors++; $display("FAIL %s rsp_valid: got %b expected %b", nm, rsp_valid, oh);
    end
    checks++;
    if (rsp_err !== exp_err) begin
      errors++; $display("FAIL %s rsp_err: got %b expected %b", nm, rsp_err, exp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_cnt = 1'b0;
    req_valid = 2'b11; req_data = '0; req_parity = '0; req_odd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b rsp_valid=%b err=%b expected 00/00/0", req_ready, rsp_valid, rsp_err);
    end
    checks++;
    if (err_cnt !== 16'h0000 || err_cnt2 !== 4'h0) begin
      errors++; $display("FAIL reset_counters: got %h/%h expected 0000/0", err_cnt, err_cnt2);
    end
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_req(0, 4'b1011, 1'b1, 1'b0, 1'b0, "single_req0");
    checks++;
    if (err_cnt[7:0] !== 8'd0) begin
      errors++; $display("FAIL single_cnt0: got %0d expected 0", err_cnt[7:0]);
    end
  endtask

  task automatic test_modes();
    do_req(1, 4'b1011, 1'b0, 1'b1, 1'b0, "odd_ok");
    do_req(1, 4'b1011, 1'b1, 1'b1, 1'b1, "odd_bad");
    checks++;
    if (err_cnt[15:8] !== 8'd1) begin
      errors++; $display("FAIL mode_cnt1_a: got %0d expected 1", err_cnt[15:8]);
    end
    do_req(1, 4'b0000, 1'b1, 1'b0, 1'b1, "even_bad");
    checks++;
    if (err_cnt[15:8] !== 8'd2) begin
      errors++; $display("FAIL mode_cnt1_b: got %0d expected 2", err_cnt[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ready;
    logic [1:0] exp_rsp;
    test_reset();
    req_data = 8'h00; req_parity = 2'b00; req_odd = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      exp_ready = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp   = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp) begin
        errors++;
        $display("FAIL rr_cycle%0d: got ready=%b rsp_valid=%b expected %b/%b", k, req_ready, rsp_valid, exp_ready, exp_rsp);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_sweep();
    logic [3:0] d;
    logic p, o, e;
    for (int n = 0; n < 64; n++) begin
      d = n[3:0]; p = n[4]; o = n[5];
      e = (^{d, p}) ^ o;
      do_req(0, d, p, o, e, $sformatf("sweep%0d", n));
    end
    checks++;
    if (err_cnt[7:0] !== 8'd32) begin
      errors++; $display("FAIL sweep_cnt0: got %0d expected 32", err_cnt[7:0]);
    end
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 16'h0000 || err_cnt2 !== 4'h0) begin
      errors++; $display("FAIL clr_all: got %h/%h expected 0000/0", err_cnt, err_cnt2);
    end
    for (int n = 0; n < 5; n++) do_req(0, 4'b0000, 1'b1, 1'b0, 1'b1, "sat_req");
    checks++;
    if (err_cnt2[1:0] !== 2'd3) begin
      errors++; $display("FAIL sat_cnt0: got %0d expected 3", err_cnt2[1:0]);
    end
    checks++;
    if (err_cnt[7:0] !== 8'd5) begin
      errors++; $display("FAIL wide_cnt0: got %0d expected 5", err_cnt[7:0]);
    end
    req_valid[0] = 1'b1; req_data[3:0] = 4'b0000; req_parity[0] = 1'b1; req_odd[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL clr_resp: got rsp_valid=%b err=%b expected 01/1", rsp_valid, rsp_err);
    end
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt[7:0] !== 8'd0 || err_cnt2[1:0] !== 2'd0) begin
      errors++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", err_cnt[7:0], err_cnt2[1:0]);
    end
  endtask

  task automatic test_reset_mid();
    do_req(0, 4'b0001, 1'b0, 1'b0, 1'b1, "pre_rst");
    checks++;
    if (err_cnt[7:0] !== 8'd1) begin
      errors++; $display("FAIL pre_rst_cnt0: got %0d expected 1", err_cnt[7:0]);
    end
    req_valid[0] = 1'b1; req_data[3:0] = 4'b0001; req_parity[0] = 1'b0; req_odd[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || req_ready !== 2'b00 || err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rsp_valid=%b err=%b ready=%b cnt=%h expected 00/0/00/0000", rsp_valid, rsp_err, req_ready, err_cnt);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++; $display("FAIL rst_mid_no_rsp: got %b expected 00", rsp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_regrant: got %b expected 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL rst_regrant_rsp: got rsp_valid=%b err=%b expected 01/1", rsp_valid, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_back_to_back();
    test_sweep();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
